// File: rtl/lane_reduce_accum.sv
// lane_reduce_accum: streaming lane-wise reduction of PORT_NUM words per beat, accumulated over a frame
// with one held result per frame (valid/ready on both sides).
module lane_reduce_accum #(
   parameter int PORT_NUM = 8,
   parameter int WIDTH    = 7,
   parameter int CNT_W    = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic [PORT_NUM*WIDTH-1:0] in_data_i,
   input  logic                      in_last_i,
   input  logic [1:0]                mode_i,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic [WIDTH-1:0]          out_vec_o,
   output logic                      out_bit_o,
   output logic [CNT_W-1:0]          out_count_o
);
   logic [WIDTH-1:0] acc_q, acc_d, br_and, br_or, br_xor, br, acc_n, vec_q, vec_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_n, count_q, count_d;
   logic [1:0]       fmode_q, fmode_d, m;
   logic             active_q, active_d, valid_q, valid_d, bit_q, bit_d, accept;

   function automatic logic [WIDTH-1:0] op_f(input logic [1:0] md, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      return md == 2'b01 ? (a | b) : md == 2'b10 ? (a ^ b) : (a & b);
   endfunction

   always_comb begin
      br_and = '1;
      br_or  = '0;
      br_xor = '0;
      for (int p = 0; p < PORT_NUM; p++) begin
         br_and &= in_data_i[p*WIDTH +: WIDTH];
         br_or  |= in_data_i[p*WIDTH +: WIDTH];
         br_xor ^= in_data_i[p*WIDTH +: WIDTH];
      end
   end

   assign in_ready_o  = !valid_q || out_ready_i;
   assign accept      = in_valid_i && in_ready_o;
   // A first beat uses the incoming mode; mid-frame the latched one wins.
   assign m           = active_q ? fmode_q : mode_i;
   assign br          = m == 2'b01 ? br_or : m == 2'b10 ? br_xor : br_and;
   assign acc_n       = active_q ? op_f(m, acc_q, br) : br;
   assign cnt_n       = !active_q ? CNT_W'(1) : (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

   always_comb begin
      acc_d    = accept ? acc_n : acc_q;
      cnt_d    = accept ? cnt_n : cnt_q;
      fmode_d  = accept ? m : fmode_q;
      active_d = accept ? !in_last_i : active_q;
      valid_d  = (accept && in_last_i) ? 1'b1 : out_ready_i ? 1'b0 : valid_q;
      vec_d    = vec_q;
      bit_d    = bit_q;
      count_d  = count_q;
      if (accept && in_last_i) begin
         vec_d   = m == 2'b11 ? ~acc_n : acc_n;
         bit_d   = m == 2'b00 ? &acc_n : m == 2'b01 ? |acc_n : m == 2'b10 ? ^acc_n : ~&acc_n;
         count_d = cnt_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         cnt_q    <= '0;
         fmode_q  <= 2'b00;
         active_q <= 1'b0;
         valid_q  <= 1'b0;
         vec_q    <= '0;
         bit_q    <= 1'b0;
         count_q  <= '0;
      end else begin
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         fmode_q  <= fmode_d;
         active_q <= active_d;
         valid_q  <= valid_d;
         vec_q    <= vec_d;
         bit_q    <= bit_d;
         count_q  <= count_d;
      end
   end

   assign out_valid_o = valid_q;
   assign out_vec_o   = vec_q;
   assign out_bit_o   = bit_q;
   assign out_count_o = count_q;
endmodule

// File: tb/tb_lane_reduce_accum.sv
// tb_lane_reduce_accum: directed checks of lane_reduce_accum; a second CNT_W=2 instance shares the stimulus
// to exercise count saturation.
module tb_lane_reduce_accum;
   localparam int PN = 8;
   localparam int W  = 7;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
   logic [PN*W-1:0] in_data = '0;
   logic [1:0]    mode = 2'b00;
   logic          in_ready, out_valid, out_bit, in_ready2, out_valid2, out_bit2;
   logic [W-1:0]  out_vec, out_vec2;
   logic [7:0]    out_count;
   logic [1:0]    out_count2;
   int            checks = 0, fails = 0;

   always #5 clk = ~clk;

   lane_reduce_accum #(.PORT_NUM(PN), .WIDTH(W), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
      .in_last_i(in_last), .mode_i(mode), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_vec_o(out_vec), .out_bit_o(out_bit), .out_count_o(out_count));

   lane_reduce_accum #(.PORT_NUM(PN), .WIDTH(W), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready2), .in_data_i(in_data),
      .in_last_i(in_last), .mode_i(mode), .out_valid_o(out_valid2), .out_ready_i(out_ready),
      .out_vec_o(out_vec2), .out_bit_o(out_bit2), .out_count_o(out_count2));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [1:0] md, input logic [PN*W-1:0] d, input logic last);
      in_valid = 1'b1;
      mode     = md;
      in_data  = d;
      in_last  = last;
      step();
      in_valid = 1'b0;
   endtask

   task automatic res(input string tag, input logic [W-1:0] v, input logic b, input logic [7:0] c);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_vec"}, 32'(out_vec), 32'(v));
      chk({tag, "_bit"}, 32'(out_bit), 32'(b));
      chk({tag, "_count"}, 32'(out_count), 32'(c));
   endtask

   initial begin
      logic [PN*W-1:0] d;
      #3;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_vec", 32'(out_vec), 32'd0);
      chk("rst_count", 32'(out_count), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      step();
      // AND single-beat frames
      beat(2'b00, {PN{7'h7F}}, 1'b1);
      res("and_all", 7'h7F, 1'b1, 8'd1);
      d = {PN{7'h7F}};
      d[3*W +: W] = 7'h7E;
      beat(2'b00, d, 1'b1);
      res("and_p3", 7'h7E, 1'b0, 8'd1);
      // OR over three beats
      d = '0;
      d[0 +: W] = 7'h01;
      beat(2'b01, d, 1'b0);
      chk("or_drained", 32'(out_valid), 32'd0);
      chk("or_stale_vec", 32'(out_vec), 32'h7E);
      d = '0;
      d[5*W +: W] = 7'h10;
      beat(2'b10, d, 1'b0);
      chk("or_mid_valid", 32'(out_valid), 32'd0);
      beat(2'b00, '0, 1'b1);
      res("or3", 7'h11, 1'b1, 8'd3);
      // XOR parity
      d = '0;
      d[0 +: W] = 7'h55;
      beat(2'b10, d, 1'b0);
      d[0 +: W] = 7'h0F;
      beat(2'b10, d, 1'b1);
      res("xor2", 7'h5A, 1'b0, 8'd2);
      // Backpressure: offered beat must not be taken while result is held
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_last   = 1'b1;
      mode      = 2'b00;
      in_data   = '0;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_ready", 32'(in_ready), 32'd0);
         res("bp_hold", 7'h5A, 1'b0, 8'd2);
         step();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_ready_comb", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      res("bp_replace", 7'h00, 1'b0, 8'd1);
      // Mode change mid-frame ignored (NAND kept)
      beat(2'b11, {PN{7'h7F}}, 1'b0);
      beat(2'b01, {PN{7'h7F}}, 1'b1);
      res("nand_keep", 7'h00, 1'b0, 8'd2);
      // Saturation: 5 beats, CNT_W=2 instance clamps at 3
      d = '0;
      d[0 +: W] = 7'h40;
      for (int i = 0; i < 4; i++) beat(2'b01, d, 1'b0);
      beat(2'b01, d, 1'b1);
      res("sat5", 7'h40, 1'b1, 8'd5);
      chk("sat_cnt2", 32'(out_count2), 32'd3);
      chk("sat_vec2", 32'(out_vec2), 32'h40);
      // Async reset mid-frame
      beat(2'b10, {PN{7'h11}}, 1'b0);
      beat(2'b10, {PN{7'h22}}, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_vec", 32'(out_vec), 32'd0);
      chk("arst_bit", 32'(out_bit), 32'd0);
      chk("arst_count", 32'(out_count), 32'd0);
      chk("arst_ready", 32'(in_ready), 32'd1);
      #1;
      rst_n = 1'b1;
      step();
      d = '0;
      d[0 +: W] = 7'h03;
      beat(2'b01, d, 1'b1);
      res("post_rst", 7'h03, 1'b1, 8'd1);
      step();
      chk("final_drain", 32'(out_valid), 32'd0);
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
